// File: rtl/adder_result_stage.sv
// Result stage for a wide adder: derives carry/overflow/zero/negative flags from a trusted sum
// and buffers {sum, flags} in a 2-entry in-order skid FIFO, with a saturating overflow counter.
module adder_result_stage #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNTW-1:0]  ovf_count,
  input  logic             ovf_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int EW = WIDTH + 4;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_next;

  logic [EW-1:0] head;
  logic [EW-1:0] skid;
  logic [EW-1:0] entry_in;

  logic push;
  logic pop;
  logic c_msb;
  logic flag_carry;
  logic flag_ovf;
  logic flag_zero;
  logic flag_neg;
  logic load_head_in;
  logic load_head_skid;
  logic load_skid;

  // Only the MSBs of the operands matter; the sum itself is taken on trust.
  logic unused_bits;
  assign unused_bits = ^{c_in, a[WIDTH-2:0], b[WIDTH-2:0]};

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Recover the carry into the MSB from the sum bit, then carry-out and overflow.
  always_comb begin
    c_msb      = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
    flag_carry = (a[WIDTH-1] & b[WIDTH-1]) | (a[WIDTH-1] & c_msb) | (b[WIDTH-1] & c_msb);
    flag_ovf   = c_msb ^ flag_carry;
    flag_zero  = (sum == '0);
    flag_neg   = sum[WIDTH-1];
    entry_in   = {sum, flag_carry, flag_ovf, flag_zero, flag_neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Head register always presents the oldest entry; skid catches a push while head is stalled.
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in) begin
        head <= entry_in;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid) begin
        skid <= entry_in;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (push && flag_ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_sum   = head[EW-1:4];
  assign out_carry = head[3];
  assign out_ovf   = head[2];
  assign out_zero  = head[1];
  assign out_neg   = head[0];

endmodule

// File: doc/adder_result_stage.md
ADDER_RESULT_STAGE -- requirements
Module: adder_result_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n (async assert, sync deassert external).
REQ-002 Parameter: WIDTH, default 64, operand/result width; CNTW, default 16, overflow counter width.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  upstream adder result valid
- in_ready  out  1  stage can accept
- a  in  WIDTH  adder operand a
- b  in  WIDTH  adder operand b
- c_in  in  1  adder carry-in
- sum  in  WIDTH  adder sum for (a, b, c_in)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_sum  out  WIDTH  registered sum
- out_carry  out  1  unsigned carry-out of MSB
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_neg  out  1  out_sum[WIDTH-1]
- ovf_count  out  CNTW  saturating count of accepted overflowing results
- ovf_clr  in  1  synchronous clear of ovf_count

Function
REQ-004 Push SHALL occur on a rising edge with in_valid & in_ready; pop SHALL occur on a rising edge with out_valid & out_ready.
REQ-005 Flags SHALL be computed at push from the inputs: c_msb = a[W-1]^b[W-1]^sum[W-1]; carry = majority(a[W-1], b[W-1], c_msb); ovf = c_msb ^ carry; zero = (sum==0); neg = sum[W-1].
REQ-006 The stage SHALL trust sum; no recomputation or checking of a+b+c_in.
REQ-007 Storage SHALL be a 2-entry in-order FIFO (skid buffer) holding {sum, carry, ovf, zero, neg}; occupancy states EMPTY, ONE, FULL.
REQ-008 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new entry becomes head next cycle); FULL+pop->ONE; no event->hold.
REQ-009 in_ready SHALL equal (state != FULL), driven only from registered state (no combinational path from out_ready).
REQ-010 out_valid SHALL equal (state != EMPTY); out_* fields SHALL present the head entry.
REQ-011 Latency SHALL be one cycle: data pushed at edge N is visible on out_* with out_valid=1 after edge N when the FIFO was EMPTY.
REQ-012 While out_valid & !out_ready, out_* SHALL remain stable.
REQ-013 Ordering SHALL be strictly first-in first-out; no entry lost or duplicated.
REQ-014 ovf_count SHALL increment by 1 on each push with ovf=1, saturating at 2^CNTW-1 (no wrap).
REQ-015 ovf_clr SHALL set ovf_count to 0 on the next edge and SHALL take priority over a simultaneous increment (result 0).
REQ-016 Flag outputs SHALL be registered copies; no combinational path from a/b/sum to out_*.

Reset
REQ-017 On rst_n low, immediately and asynchronously: state EMPTY, out_valid=0, in_ready=1, out_sum=0, out_carry=0, out_ovf=0, out_zero=0, out_neg=0, ovf_count=0.
REQ-018 Reset mid-operation SHALL discard all buffered entries; first push after release behaves as from EMPTY.

Verification
REQ-019 a=3, b=4, c_in=1, sum=8, out_ready=1 -> one cycle later out_valid=1, out_sum=8, carry=0, ovf=0, zero=0, neg=0.
REQ-020 a=b=0x8000_0000_0000_0000, c_in=0, sum=0 -> carry=1, ovf=1, zero=1, neg=0, ovf_count 0->1.
REQ-021 a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, sum=0 -> carry=1, ovf=0, zero=1; a=0x7FFF_FFFF_FFFF_FFFF, b=1, c_in=0, sum=0x8000_0000_0000_0000 -> carry=0, ovf=1, neg=1.
REQ-022 out_ready=0, offer sums 10,20,30 back-to-back -> in_ready=0 after second push, 30 held upstream; out_ready=1 -> outputs 10,20,30 in order, out_sum stable while stalled.
REQ-023 Drive 2^16+5 overflowing pushes -> ovf_count=0xFFFF; then ovf_clr=1 with an overflowing push same cycle -> ovf_count=0.
REQ-024 FULL with out_ready=0, pull rst_n low mid-cycle -> out_valid=0 and in_ready=1 without a clock edge; after release, push sum=5 -> out_sum=5 one cycle later.
